// File: rtl/mant_align.sv
// Mantissa alignment stage: right-shifts a normalized mantissa by (exp_max - exp)
// through a two-stage valid/ready pipeline, producing a sticky bit and an exponent error flag.
module mant_align #(
    parameter int WIDTH     = 8,
    parameter int EXP_WIDTH = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [WIDTH-1:0]     operand_i,
    input  logic [EXP_WIDTH:0]   exp_i,
    input  logic [EXP_WIDTH:0]   exp_max_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [WIDTH-1:0]     operand_o,
    output logic                 sticky_o,
    output logic                 exp_err_o
);

    localparam int SW = $clog2(WIDTH + 1);

    logic                      s1_valid_r;
    logic [WIDTH-1:0]          s1_operand_r;
    logic [SW-1:0]             s1_shift_r;
    logic                      s1_err_r;

    logic                      s2_valid_r;
    logic [WIDTH-1:0]          s2_operand_r;
    logic                      s2_sticky_r;
    logic                      s2_err_r;

    logic                      s1_en_s;
    logic                      s2_en_s;
    logic signed [EXP_WIDTH+1:0] diff_s;
    logic [SW-1:0]             shift_s;
    logic                      err_s;
    logic [2*WIDTH-1:0]        wide_s;

    assign s2_en_s = !s2_valid_r || ready_i;
    assign s1_en_s = !s1_valid_r || s2_en_s;
    assign ready_o = s1_en_s;

    // Sign-extend by one bit so the difference of two signed exponents cannot overflow.
    assign diff_s = {exp_max_i[EXP_WIDTH], exp_max_i} - {exp_i[EXP_WIDTH], exp_i};

    // Shift amount: negative distance is an error, large distance saturates to a full flush.
    always_comb begin
        shift_s = {SW{1'b0}};
        err_s   = 1'b0;
        if (diff_s[EXP_WIDTH+1]) begin
            shift_s = {SW{1'b0}};
            err_s   = 1'b1;
        end else if (int'(diff_s) >= WIDTH) begin
            shift_s = SW'(WIDTH);
            err_s   = 1'b0;
        end else begin
            shift_s = SW'(diff_s);
            err_s   = 1'b0;
        end
    end

    // Upper half is the aligned mantissa, lower half holds exactly the bits shifted out.
    assign wide_s = {s1_operand_r, {WIDTH{1'b0}}} >> s1_shift_r;

    // Stage 1 register: operand with its decoded shift amount and error flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid_r   <= 1'b0;
            s1_operand_r <= {WIDTH{1'b0}};
            s1_shift_r   <= {SW{1'b0}};
            s1_err_r     <= 1'b0;
        end else if (s1_en_s) begin
            s1_valid_r <= valid_i;
            if (valid_i) begin
                s1_operand_r <= operand_i;
                s1_shift_r   <= shift_s;
                s1_err_r     <= err_s;
            end
        end
    end

    // Stage 2 register: shifted mantissa, sticky and error, held while downstream stalls.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s2_valid_r   <= 1'b0;
            s2_operand_r <= {WIDTH{1'b0}};
            s2_sticky_r  <= 1'b0;
            s2_err_r     <= 1'b0;
        end else if (s2_en_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                s2_operand_r <= wide_s[2*WIDTH-1:WIDTH];
                s2_sticky_r  <= |wide_s[WIDTH-1:0];
                s2_err_r     <= s1_err_r;
            end
        end
    end

    assign valid_o   = s2_valid_r;
    assign operand_o = s2_operand_r;
    assign sticky_o  = s2_sticky_r;
    assign exp_err_o = s2_err_r;

endmodule

// File: tb/tb_mant_align.sv
// Self-checking bench for mant_align: directed vectors, backpressure, full-rate
// random stream against a bit-loop reference, and asynchronous reset mid-stream.
module tb_mant_align;

    localparam int WIDTH     = 8;
    localparam int EXP_WIDTH = 3;

    logic                 clk;
    logic                 rst_ni;
    logic                 valid_i;
    logic                 ready_o;
    logic [WIDTH-1:0]     operand_i;
    logic [EXP_WIDTH:0]   exp_i;
    logic [EXP_WIDTH:0]   exp_max_i;
    logic                 valid_o;
    logic                 ready_i;
    logic [WIDTH-1:0]     operand_o;
    logic                 sticky_o;
    logic                 exp_err_o;

    int checks   = 0;
    int failures = 0;

    logic [7:0] v_op   [32];
    logic [3:0] v_exp  [32];
    logic [3:0] v_emax [32];
    logic [7:0] x_op   [32];
    logic       x_sticky [32];
    logic       x_err    [32];

    mant_align #(.WIDTH(WIDTH), .EXP_WIDTH(EXP_WIDTH)) dut (
        .clk_i     (clk),
        .rst_ni    (rst_ni),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .operand_i (operand_i),
        .exp_i     (exp_i),
        .exp_max_i (exp_max_i),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .operand_o (operand_o),
        .sticky_o  (sticky_o),
        .exp_err_o (exp_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_vec(input int i, input logic [7:0] op, input logic [3:0] e, input logic [3:0] m,
                           input logic [7:0] xo, input logic xs, input logic xe);
        v_op[i] = op; v_exp[i] = e; v_emax[i] = m;
        x_op[i] = xo; x_sticky[i] = xs; x_err[i] = xe;
    endtask

    // Reference: bit-by-bit shift with sticky collected from the low bits that fall off.
    function automatic logic [9:0] ref_align(input logic [7:0] op, input logic [3:0] e, input logic [3:0] m);
        int d;
        int sh;
        logic [7:0] r;
        logic s;
        logic er;
        d  = int'($signed(m)) - int'($signed(e));
        er = (d < 0);
        sh = er ? 0 : ((d > 8) ? 8 : d);
        r  = 8'h00;
        s  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i + sh < 8) r[i] = op[i + sh];
            if (i < sh) s = s | op[i];
        end
        return {er, s, r};
    endfunction

    task automatic run_stream(input int n, input int stall_lo, input int stall_hi,
                              input bit timed, input string name);
        int in_idx = 0;
        int out_idx = 0;
        bit hold = 1'b0;
        logic [10:0] held = 11'h000;
        for (int cyc = 0; cyc < 200 && out_idx < n; cyc++) begin
            @(negedge clk);
            ready_i = !(cyc >= stall_lo && cyc <= stall_hi);
            valid_i = (in_idx < n);
            if (in_idx < n) begin
                operand_i = v_op[in_idx]; exp_i = v_exp[in_idx]; exp_max_i = v_emax[in_idx];
            end else begin
                operand_i = 8'h00; exp_i = 4'h0; exp_max_i = 4'h0;
            end
            #1;
            if (hold)
                check_value({name, "_hold"}, 32'({valid_o, exp_err_o, sticky_o, operand_o}), 32'(held));
            if (cyc >= stall_lo && cyc <= stall_hi)
                check_value({name, "_ready_o_low"}, 32'(ready_o), 32'd0);
            if (valid_o && ready_i) begin
                check_value({name, "_operand"}, 32'(operand_o), 32'(x_op[out_idx]));
                check_value({name, "_sticky"}, 32'(sticky_o), 32'(x_sticky[out_idx]));
                check_value({name, "_err"}, 32'(exp_err_o), 32'(x_err[out_idx]));
                if (timed) check_value({name, "_latency"}, 32'(cyc), 32'(out_idx + 2));
                out_idx++;
            end
            hold = valid_o && !ready_i;
            held = {valid_o, exp_err_o, sticky_o, operand_o};
            if (valid_i && ready_o) in_idx++;
        end
        check_value({name, "_count"}, 32'(out_idx), 32'(n));
        @(negedge clk);
        valid_i = 1'b0;
        ready_i = 1'b1;
        #1;
        check_value({name, "_drained"}, 32'(valid_o), 32'd0);
    endtask

    initial begin
        logic [9:0] r;
        rst_ni = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
        operand_i = 8'h00; exp_i = 4'h0; exp_max_i = 4'h0;
        #1;
        check_value("rst_valid_o", 32'(valid_o), 32'd0);
        check_value("rst_operand_o", 32'(operand_o), 32'd0);
        check_value("rst_sticky_o", 32'(sticky_o), 32'd0);
        check_value("rst_err_o", 32'(exp_err_o), 32'd0);
        check_value("rst_ready_o", 32'(ready_o), 32'd1);
        @(negedge clk);
        rst_ni = 1'b1;

        // Directed vectors, full rate: exp values are 4-bit two's complement.
        set_vec(0, 8'hB0, 4'd1,  4'd3, 8'h2C, 1'b0, 1'b0);
        set_vec(1, 8'h83, 4'hE,  4'd1, 8'h10, 1'b1, 1'b0);
        set_vec(2, 8'hFF, 4'h8,  4'd7, 8'h00, 1'b1, 1'b0);
        set_vec(3, 8'hA0, 4'd3,  4'd2, 8'hA0, 1'b0, 1'b1);
        set_vec(4, 8'h00, 4'h8,  4'd7, 8'h00, 1'b0, 1'b0);
        set_vec(5, 8'hFF, 4'd0,  4'd7, 8'h01, 1'b1, 1'b0);
        set_vec(6, 8'h80, 4'hF,  4'd7, 8'h00, 1'b1, 1'b0);
        set_vec(7, 8'h5A, 4'd2,  4'd2, 8'h5A, 1'b0, 1'b0);
        set_vec(8, 8'h01, 4'd0,  4'd1, 8'h00, 1'b1, 1'b0);
        run_stream(9, 100, 0, 1'b1, "dir");

        // Five beats with downstream stalled on cycles 3..6.
        set_vec(0, 8'hB0, 4'd1,  4'd3, 8'h2C, 1'b0, 1'b0);
        set_vec(1, 8'h83, 4'hE,  4'd1, 8'h10, 1'b1, 1'b0);
        set_vec(2, 8'hFF, 4'h8,  4'd7, 8'h00, 1'b1, 1'b0);
        set_vec(3, 8'hA0, 4'd3,  4'd2, 8'hA0, 1'b0, 1'b1);
        set_vec(4, 8'hC4, 4'd0,  4'd2, 8'h31, 1'b0, 1'b0);
        run_stream(5, 3, 6, 1'b0, "bp");

        for (int i = 0; i < 20; i++) begin
            v_op[i]   = 8'($urandom);
            v_exp[i]  = 4'($urandom);
            v_emax[i] = 4'($urandom);
            r = ref_align(v_op[i], v_exp[i], v_emax[i]);
            set_vec(i, v_op[i], v_exp[i], v_emax[i], r[7:0], r[8], r[9]);
        end
        run_stream(20, 100, 0, 1'b1, "rand");

        // Fill both stages under backpressure, then reset asynchronously.
        @(negedge clk);
        ready_i = 1'b0; valid_i = 1'b1;
        operand_i = 8'hB0; exp_i = 4'd1; exp_max_i = 4'd3;
        @(negedge clk);
        operand_i = 8'hC4; exp_i = 4'd0; exp_max_i = 4'd2;
        @(negedge clk);
        valid_i = 1'b0;
        #1;
        check_value("pre_rst_valid_o", 32'(valid_o), 32'd1);
        check_value("pre_rst_ready_o", 32'(ready_o), 32'd0);
        check_value("pre_rst_operand_o", 32'(operand_o), 32'h2C);
        #1;
        rst_ni = 1'b0;
        #1;
        check_value("mid_rst_valid_o", 32'(valid_o), 32'd0);
        check_value("mid_rst_operand_o", 32'(operand_o), 32'd0);
        check_value("mid_rst_sticky_o", 32'(sticky_o), 32'd0);
        check_value("mid_rst_err_o", 32'(exp_err_o), 32'd0);
        @(negedge clk);
        rst_ni = 1'b1;
        ready_i = 1'b1;
        set_vec(0, 8'h83, 4'hE, 4'd1, 8'h10, 1'b1, 1'b0);
        run_stream(1, 100, 0, 1'b1, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mant_align.md
Name: mant_align

Overview:
- Mantissa alignment (denormalization) stage of the posit dot-product datapath; inverse of the normalizer.
- Takes a normalized mantissa with its signed exponent plus the group's maximum exponent, and right-shifts the mantissa by (exp_max - exp).
- Produces an aligned mantissa and a sticky bit for accumulation.
- Two-stage pipeline with valid/ready handshake; sits between the product/decode stage and the adder tree.

Parameters:
- WIDTH, 8, mantissa width in bits.
- EXP_WIDTH, 3, exponent magnitude width; exponents are signed EXP_WIDTH+1 bits.

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  asynchronous active-low reset
- valid_i  input  1  upstream data valid
- ready_o  output  1  block can accept input this cycle
- operand_i  input  WIDTH  normalized mantissa, MSB-aligned
- exp_i  input  EXP_WIDTH+1  signed exponent of operand_i
- exp_max_i  input  EXP_WIDTH+1  signed group maximum exponent
- valid_o  output  1  output data valid
- ready_i  input  1  downstream accepts output
- operand_o  output  WIDTH  aligned mantissa
- sticky_o  output  1  OR of all bits shifted out
- exp_err_o  output  1  exp_i exceeded exp_max_i for this beat

Behaviour:
- Reset (rst_ni low, asynchronous): both stage valid flags = 0; all data registers = 0. valid_o, operand_o, sticky_o and exp_err_o read 0.
- Stage 1 (S1):
  - diff = exp_max_i - exp_i, computed signed at EXP_WIDTH+2 bits (no overflow).
  - If diff < 0: shift = 0 and err = 1.
  - Else if diff >= WIDTH: shift saturates to WIDTH and err = 0.
  - Else: shift = diff and err = 0.
  - Registered together with operand_i.
- Stage 2 (S2):
  - Logical right shift of the S1 operand by shift; zeros fill from the MSB.
  - sticky = OR of the bits shifted out.
  - shift = WIDTH -> operand_o = 0, sticky = |operand.
  - Operand 0 -> result 0, sticky 0, for any shift.
  - Results registered; operand_o, sticky_o and exp_err_o come from the S2 registers.
- Latency: 2 cycles from input handshake to valid_o, with no stall.
- Throughput: 1 beat/cycle.
- Handshake:
  - An input transfer occurs when valid_i && ready_o.
  - An output transfer occurs when valid_o && ready_i.
  - Each stage loads when its register is empty or is being drained in the same cycle:
    - s2_en = !s2_valid | ready_i
    - s1_en = !s1_valid | s2_en
    - ready_o = s1_en
  - Stage registers hold their contents when not enabled.
  - A stage's valid clears when it is drained and not refilled.
- Data stability:
  - While valid_o = 1 and ready_i = 0, operand_o, sticky_o and exp_err_o stay stable.
  - ready_o is combinational from ready_i (no skid buffer). Upstream may not rely on ready_o being registered.
- Simultaneous events: when an input and an output transfer occur in the same cycle with both stages full, the pipeline shifts with no bubble and no data loss.
- Ordering: beats leave in arrival order; no beat is ever dropped or duplicated.
- Data gating: data registers update only when the stage is enabled and the upstream valid is 1. The valid bit follows the enable.
- Reset mid-operation: in-flight beats are discarded, and valid_o falls immediately (asynchronously).

Test Plan:
- Basic shift: WIDTH=8; operand 8'b1011_0000, exp 1, exp_max 3, ready_i=1 -> after 2 cycles, operand_o 8'b0010_1100, sticky 0, err 0.
- Sticky: operand 8'b1000_0011, exp -2, exp_max 1 (shift 3) -> operand_o 8'b0001_0000, sticky 1.
- Saturation and error:
  - exp -8, exp_max 7 (diff 15): operand 8'hFF -> operand_o 0, sticky 1.
  - exp 3, exp_max 2: operand 8'hA0 -> operand_o 8'hA0, err 1.
- Backpressure:
  - Stream 5 beats with ready_i=0 for cycles 3-6: ready_o drops once both stages are full; outputs stay stable.
  - After ready_i=1, all 5 beats emerge in order with no loss or duplicates.
- Full throughput: continuous valid_i and ready_i for 20 random beats -> one result per cycle after 2-cycle latency, matching a reference model.
- Reset mid-stream:
  - Assert rst_ni low with both stages valid -> valid_o=0 and outputs 0 immediately.
  - After release, the first new beat appears 2 cycles after acceptance.
